// File: rtl/axil_reg_arbiter_if.sv
// rtl/axil_reg_arbiter_if.sv - AXI-lite bus between the request arbiter and the register slave
interface axil_reg_arbiter_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32
);
    logic                      awvalid;
    logic                      awready;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic [2:0]                awprot;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic                      arvalid;
    logic                      arready;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic [2:0]                arprot;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axil_reg_arbiter.sv
// rtl/axil_reg_arbiter.sv - round-robin two-client arbiter sequencing one AXI-lite transaction at a time
module axil_reg_arbiter #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32
) (
    input  logic                        S_AXI_ACLK,
    input  logic                        S_AXI_ARESETN,
    input  logic [1:0]                  REQ_VALID,
    output logic [1:0]                  REQ_READY,
    input  logic [1:0]                  REQ_WE,
    input  logic [2*ADDR_WIDTH-1:0]     REQ_ADDR,
    input  logic [2*DATA_WIDTH-1:0]     REQ_WDATA,
    input  logic [2*DATA_WIDTH/8-1:0]   REQ_WSTRB,
    output logic [1:0]                  RSP_VALID,
    output logic [DATA_WIDTH-1:0]       RSP_RDATA,
    output logic [1:0]                  RSP_RESP,
    axil_reg_arbiter_if.master          m_axi
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, DONE} state_e;

    state_e                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic                    gnt_q, gnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    arvalid_q, arvalid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;

    logic                    grant;
    logic                    accept;

    // On a tie the client that was not served last wins.
    always_comb begin
        grant = 1'b0;
        unique case (REQ_VALID)
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant_q;
            default: grant = 1'b0;
        endcase
    end

    assign accept    = (state_q == IDLE) && (REQ_VALID != 2'b00);
    assign REQ_READY = (accept && S_AXI_ARESETN) ? (grant ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        arvalid_d    = arvalid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_resp_d   = rsp_resp_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    gnt_d        = grant;
                    last_grant_d = grant;
                    addr_d       = grant ? REQ_ADDR[2*ADDR_WIDTH-1:ADDR_WIDTH] : REQ_ADDR[ADDR_WIDTH-1:0];
                    wdata_d      = grant ? REQ_WDATA[2*DATA_WIDTH-1:DATA_WIDTH] : REQ_WDATA[DATA_WIDTH-1:0];
                    wstrb_d      = grant ? REQ_WSTRB[2*STRB_WIDTH-1:STRB_WIDTH] : REQ_WSTRB[STRB_WIDTH-1:0];
                    if (REQ_WE[grant]) begin
                        state_d   = WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = READ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                // AW and W retire independently; move on once neither is still pending.
                if (m_axi.awready) awvalid_d = 1'b0;
                if (m_axi.wready)  wvalid_d  = 1'b0;
                if ((!awvalid_q || m_axi.awready) && (!wvalid_q || m_axi.wready)) begin
                    state_d = WRESP;
                end
            end
            WRESP: begin
                if (m_axi.bvalid) begin
                    rsp_resp_d  = m_axi.bresp;
                    rsp_rdata_d = '0;
                    state_d     = DONE;
                end
            end
            READ: begin
                if (m_axi.arready) begin
                    arvalid_d = 1'b0;
                    state_d   = RDATA;
                end
            end
            RDATA: begin
                if (m_axi.rvalid) begin
                    rsp_resp_d  = m_axi.rresp;
                    rsp_rdata_d = m_axi.rdata;
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_resp_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            arvalid_q    <= arvalid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_resp_q   <= rsp_resp_d;
        end
    end

    assign m_axi.awvalid = awvalid_q;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.bready  = (state_q == WRESP);
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.rready  = (state_q == RDATA);

    assign RSP_VALID = (state_q == DONE) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign RSP_RDATA = rsp_rdata_q;
    assign RSP_RESP  = rsp_resp_q;
endmodule

// File: tb/tb_axil_reg_arbiter.sv
// tb/tb_axil_reg_arbiter.sv - self-checking bench with register-bank slave and reference model
module tb_axil_reg_arbiter;
    localparam int AW = 7;
    localparam int DW = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [1:0]     req_valid = '0;
    logic [1:0]     req_ready;
    logic [1:0]     req_we = '0;
    logic [2*AW-1:0] req_addr = '0;
    logic [2*DW-1:0] req_wdata = '0;
    logic [7:0]     req_wstrb = '0;
    logic [1:0]     rsp_valid;
    logic [DW-1:0]  rsp_rdata;
    logic [1:0]     rsp_resp;

    always #5 clk = ~clk;

    axil_reg_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    axil_reg_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .REQ_VALID     (req_valid),
        .REQ_READY     (req_ready),
        .REQ_WE        (req_we),
        .REQ_ADDR      (req_addr),
        .REQ_WDATA     (req_wdata),
        .REQ_WSTRB     (req_wstrb),
        .RSP_VALID     (rsp_valid),
        .RSP_RDATA     (rsp_rdata),
        .RSP_RESP      (rsp_resp),
        .m_axi         (axi.master)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- slave: 32-word register bank, word 31 answers SLVERR ----------------
    logic [31:0] sregs [32];
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    int b_hs_cnt = 0;

    initial begin : slave
        int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, widx, ridx;
        bit aw_done, w_done, ar_done, b_fired, r_fired;
        logic [AW-1:0] waddr, raddr;
        logic [DW-1:0] wd;
        logic [3:0] ws;
        for (int i = 0; i < 32; i++) sregs[i] = '0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_done = 0; w_done = 0; ar_done = 0; b_fired = 0; r_fired = 0;
        waddr = '0; raddr = '0; wd = '0; ws = '0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
        axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                aw_done = 0; w_done = 0; ar_done = 0; b_fired = 0; r_fired = 0;
                axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
                axi.arready = 0; axi.rvalid = 0;
                continue;
            end
            // response channels first so a response follows its address handshake edge
            if (b_fired) begin
                axi.bvalid = 0; b_fired = 0;
            end else begin
                if (aw_done && w_done && !axi.bvalid) begin
                    if (b_cnt >= b_dly) begin
                        widx = int'(waddr[6:2]);
                        if (widx != 31)
                            for (int b = 0; b < 4; b++) if (ws[b]) sregs[widx][8*b +: 8] = wd[8*b +: 8];
                        axi.bvalid = 1; axi.bresp = (widx == 31) ? 2'b10 : 2'b00;
                        aw_done = 0; w_done = 0; b_cnt = 0;
                    end else b_cnt++;
                end
                if (axi.bvalid && axi.bready) begin b_fired = 1; b_hs_cnt++; end
            end
            if (r_fired) begin
                axi.rvalid = 0; r_fired = 0;
            end else begin
                if (ar_done && !axi.rvalid) begin
                    if (r_cnt >= r_dly) begin
                        ridx = int'(raddr[6:2]);
                        axi.rvalid = 1;
                        axi.rdata  = (ridx == 31) ? 32'h0 : sregs[ridx];
                        axi.rresp  = (ridx == 31) ? 2'b10 : 2'b00;
                        ar_done = 0; r_cnt = 0;
                    end else r_cnt++;
                end
                if (axi.rvalid && axi.rready) r_fired = 1;
            end
            if (axi.awvalid) begin axi.awready = (aw_cnt >= aw_dly); aw_cnt++; end
            else begin axi.awready = 0; aw_cnt = 0; end
            if (axi.awvalid && axi.awready) begin aw_done = 1; waddr = axi.awaddr; end
            if (axi.wvalid) begin axi.wready = (w_cnt >= w_dly); w_cnt++; end
            else begin axi.wready = 0; w_cnt = 0; end
            if (axi.wvalid && axi.wready) begin w_done = 1; wd = axi.wdata; ws = axi.wstrb; end
            if (axi.arvalid) begin axi.arready = (ar_cnt >= ar_dly); ar_cnt++; end
            else begin axi.arready = 0; ar_cnt = 0; end
            if (axi.arvalid && axi.arready) begin ar_done = 1; raddr = axi.araddr; end
        end
    end

    // ---------------- reference model: round-robin grants and a mirror register file ----------------
    logic [31:0] mref [32];
    int          gq[$];
    int          rsp_cnt = 0;

    initial begin : monitor
        int ref_last, exp_c, g, idx;
        bit busy, was_busy;
        logic [31:0] exp_rdata, r;
        logic [1:0] exp_resp;
        logic [3:0] s;
        ref_last = 1; busy = 0; exp_c = 0; exp_rdata = '0; exp_resp = '0;
        for (int i = 0; i < 32; i++) mref[i] = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin busy = 0; ref_last = 1; continue; end
            was_busy = busy;
            if (was_busy) check("rdy_busy", req_ready, 0);
            if (rsp_valid != 2'b00) begin
                rsp_cnt++;
                if (!busy) check("rsp_unexp", rsp_valid, 0);
                else begin
                    check("rsp_client", rsp_valid, (exp_c == 1) ? 2'b10 : 2'b01);
                    check("rsp_rdata", rsp_rdata, exp_rdata);
                    check("rsp_resp", rsp_resp, exp_resp);
                    busy = 0;
                end
            end
            if (!was_busy && req_valid != 2'b00) begin
                g = (req_valid == 2'b11) ? 1 - ref_last : (req_valid[1] ? 1 : 0);
                check("grant", req_ready, (g == 1) ? 2'b10 : 2'b01);
                busy = 1; ref_last = g; exp_c = g; gq.push_back(g);
                idx = int'(req_addr[g*AW+2 +: 5]);
                exp_resp = (idx == 31) ? 2'b10 : 2'b00;
                if (req_we[g]) begin
                    r = mref[idx]; s = req_wstrb[g*4 +: 4];
                    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = req_wdata[g*DW + 8*b +: 8];
                    if (idx != 31) mref[idx] = r;
                    exp_rdata = '0;
                end else begin
                    exp_rdata = mref[idx];
                end
            end
        end
    end

    // ---------------- client and response helpers ----------------
    task automatic issue(input int c, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [3:0] s);
        bit ok;
        ok = 0;
        @(posedge clk); #1;
        req_we[c] = we;
        req_addr[c*AW +: AW]  = a;
        req_wdata[c*DW +: DW] = d;
        req_wstrb[c*4 +: 4]   = s;
        req_valid[c] = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (req_ready[c]) ok = 1;
        end
        if (!ok) check("req_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid[c] = 1'b0;
    endtask

    task automatic rand_issue(input int c);
        logic [31:0] r1, r2, r3;
        r1 = $urandom(); r2 = $urandom(); r3 = $urandom();
        issue(c, r1[7], r1[6:0], r2, (r3[3:0] == 4'h0) ? 4'hF : r3[3:0]);
    endtask

    task automatic wait_rsp(output logic [1:0] v, output logic [DW-1:0] d, output logic [1:0] rr);
        v = '0; d = '0; rr = '0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) begin
                v = rsp_valid; d = rsp_rdata; rr = rsp_resp;
                return;
            end
        end
        check("rsp_timeout", 0, 1);
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        logic [1:0] v, rr;
        logic [DW-1:0] d;
        int hs0, rc0;
        bit inr;

        req_valid = 2'b11; req_we = 2'b11;
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_axi_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
        check("rst_rsp", {rsp_valid, rsp_resp, rsp_rdata}, 0);
        check("rst_latched", {axi.awaddr, axi.wdata, axi.wstrb, axi.awprot, axi.arprot}, 0);
        req_valid = 2'b00; req_we = 2'b00;
        @(posedge clk); #1; rst_n = 1'b1;

        // zero-wait write: handshake at T+1, response pulse seen at T+3
        issue(0, 1'b1, 7'h40, 32'h8000_0000, 4'b1000);
        @(negedge clk);
        check("t1_aw_w_valid", {axi.awvalid, axi.wvalid}, 2'b11);
        check("t1_awaddr_wstrb", {axi.awaddr, axi.wstrb, axi.wdata}, {7'h40, 4'b1000, 32'h8000_0000});
        @(negedge clk);
        check("t1_wresp", {axi.awvalid, axi.wvalid, axi.bready}, 3'b001);
        @(negedge clk);
        check("t1_rsp_pulse", {rsp_valid, rsp_resp}, {2'b01, 2'b00});
        @(negedge clk);
        check("t1_rsp_one_cycle", rsp_valid, 0);
        issue(0, 1'b0, 7'h40, 32'h0, 4'h0);
        wait_rsp(v, d, rr);
        check("t1_readback", {v, rr, d}, {2'b01, 2'b00, 32'h8000_0000});

        issue(1, 1'b1, 7'h04, 32'hDEAD_BEEF, 4'hF);
        wait_rsp(v, d, rr);
        issue(1, 1'b0, 7'h04, 32'h0, 4'h0);
        wait_rsp(v, d, rr);
        check("t2_read_reg1", {v, rr, d}, {2'b10, 2'b00, 32'hDEAD_BEEF});

        // both clients hold requests continuously: grants alternate from client 0
        reset_pulse();
        gq.delete();
        fork
            begin for (int i = 0; i < 4; i++) rand_issue(0); end
            begin for (int i = 0; i < 4; i++) rand_issue(1); end
        join
        wait_rsp(v, d, rr);
        check("t3_grant_count", gq.size(), 8);
        for (int i = 0; i < 8; i++) check("t3_alternate", gq[i], i % 2);

        // AWREADY stalls 3 cycles while W completes first
        aw_dly = 3;
        hs0 = b_hs_cnt; rc0 = rsp_cnt;
        issue(0, 1'b1, 7'h08, 32'h1234_5678, 4'hF);
        @(negedge clk);
        check("t4_both_valid", {axi.awvalid, axi.wvalid}, 2'b11);
        @(negedge clk);
        check("t4_w_dropped", {axi.awvalid, axi.wvalid}, 2'b10);
        wait_rsp(v, d, rr);
        repeat (3) @(negedge clk);
        check("t4_one_bresp", b_hs_cnt - hs0, 1);
        check("t4_one_rsp", rsp_cnt - rc0, 1);
        aw_dly = 0;

        // BVALID stalled 5 cycles while client 1 waits
        b_dly = 5;
        fork
            issue(0, 1'b1, 7'h0C, 32'hCAFE_0001, 4'hF);
            begin @(posedge clk); issue(1, 1'b0, 7'h04, 32'h0, 4'h0); end
            begin
                bit seen;
                seen = 0;
                for (int k = 0; k < 60 && !seen; k++) begin
                    @(negedge clk);
                    check("t5_rr1_hold", req_ready[1], 0);
                    if (rsp_valid[0]) seen = 1;
                end
                if (!seen) check("t5_done_timeout", 0, 1);
                else begin
                    @(negedge clk);
                    check("t5_rr1_after_done", req_ready[1], 1);
                end
            end
        join
        wait_rsp(v, d, rr);
        check("t5_client1_read", {v, d}, {2'b10, 32'hDEAD_BEEF});
        b_dly = 0;

        // reset while waiting for RVALID abandons the read
        r_dly = 10;
        issue(0, 1'b0, 7'h04, 32'h0, 4'h0);
        inr = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (axi.rready) begin inr = 1; break; end
        end
        check("t6_reach_rdata", inr, 1);
        #2; rst_n = 1'b0; #1;
        check("t6_rst_axi", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 0);
        check("t6_rst_rsp", {rsp_valid, rsp_resp, rsp_rdata}, 0);
        check("t6_rst_araddr", axi.araddr, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t6_no_rsp_in_reset", rsp_valid, 0);
        end
        r_dly = 0;
        @(posedge clk); #1; rst_n = 1'b1;
        gq.delete();
        fork
            issue(0, 1'b0, 7'h40, 32'h0, 4'h0);
            issue(1, 1'b0, 7'h04, 32'h0, 4'h0);
        join
        wait_rsp(v, d, rr);
        check("t6_grant_count", gq.size(), 2);
        check("t6_first_grant", gq[0], 0);
        check("t6_second_grant", gq[1], 1);

        // randomized traffic with random slave latencies
        for (int round = 0; round < 4; round++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
            fork
                begin
                    for (int i = 0; i < 5; i++) begin
                        repeat ($urandom_range(0, 3)) @(posedge clk);
                        rand_issue(0);
                    end
                end
                begin
                    for (int i = 0; i < 5; i++) begin
                        repeat ($urandom_range(0, 3)) @(posedge clk);
                        rand_issue(1);
                    end
                end
            join
            wait_rsp(v, d, rr);
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
